ped_signal_controller: RTL and testbench

Downstream consumer of the intersection traffic light controller's six lamp outputs. Latches pedestrian push-button requests per direction and drives WALK / DON'T WALK signal heads. A NS crosswalk runs parallel to NS traffic, so it is served only during NS green; EW is served only during EW green. Detects conflicting or dark lamp states and forces both heads to solid DON'T WALK.

---
 rtl/ped_signal_controller_if.sv | 39 +++
 rtl/ped_signal_controller.sv | 205 ++++++++++++++++++++
 tb/tb_ped_signal_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ped_signal_controller_if.sv
// Lamp, button and pedestrian-head signals between the light controller and ped_signal_controller.
// Optional countdown outputs exist only when PED_COUNTDOWN_EN is defined.
interface ped_signal_controller_if;
  logic btn_ns;
  logic btn_ew;
  logic red_ns;
  logic yellow_ns;
  logic green_ns;
  logic red_ew;
  logic yellow_ew;
  logic green_ew;
  logic walk_ns;
  logic walk_ew;
  logic dont_walk_ns;
  logic dont_walk_ew;
  logic req_pending_ns;
  logic req_pending_ew;
  logic fault;
`ifdef PED_COUNTDOWN_EN
  logic [7:0] countdown_ns;
  logic [7:0] countdown_ew;
`endif

  modport master (
    output btn_ns, btn_ew, red_ns, yellow_ns, green_ns, red_ew, yellow_ew, green_ew,
    input  walk_ns, walk_ew, dont_walk_ns, dont_walk_ew, req_pending_ns, req_pending_ew, fault
`ifdef PED_COUNTDOWN_EN
    , input countdown_ns, countdown_ew
`endif
  );

  modport slave (
    input  btn_ns, btn_ew, red_ns, yellow_ns, green_ns, red_ew, yellow_ew, green_ew,
    output walk_ns, walk_ew, dont_walk_ns, dont_walk_ew, req_pending_ns, req_pending_ew, fault
`ifdef PED_COUNTDOWN_EN
    , output countdown_ns, countdown_ew
`endif
  );
endinterface

// File: rtl/ped_signal_controller.sv
// Pedestrian WALK/DON'T WALK controller slaved to the intersection lamp outputs.
// Define PED_COUNTDOWN_EN to add the per-direction flash countdown outputs.
module ped_signal_controller #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int WALK_TIME       = 15_000_000,
  parameter int FLASH_TIME      = 8_000_000,
  parameter int BLINK_HALF      = 2_500_000,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic reset,
  ped_signal_controller_if.slave ped
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WALK  = 2'd1;
  localparam logic [1:0] ST_FLASH = 2'd2;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TIME - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  // Index 0 is NS, index 1 is EW throughout.
  logic [1:0] btn_raw;
  logic [1:0] red;
  logic [1:0] yellow;
  logic [1:0] green;
  logic [1:0] lamp_ok;
  logic [1:0] walk_vec;
  logic [1:0] dont_walk_vec;
  logic [1:0] req_vec;
  logic       fault_cond;
  logic       fault_reg;
  logic       force_idle;
`ifdef PED_COUNTDOWN_EN
  logic [7:0] countdown_arr [2];
`endif

  assign btn_raw = {ped.btn_ew, ped.btn_ns};
  assign red     = {ped.red_ew, ped.red_ns};
  assign yellow  = {ped.yellow_ew, ped.yellow_ns};
  assign green   = {ped.green_ew, ped.green_ns};

  assign fault_cond = (green[0] & green[1]) | ~lamp_ok[0] | ~lamp_ok[1];
  assign force_idle = fault_cond | fault_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_reg <= 1'b0;
    else       fault_reg <= fault_cond;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
      logic             sync1_reg;
      logic             sync2_reg;
      logic             db_level_reg;
      logic [CNT_W-1:0] db_cnt_reg;
      logic             green_prev_reg;
      logic [1:0]       state_reg;
      logic [CNT_W-1:0] timer_reg;
      logic [CNT_W-1:0] blink_cnt_reg;
      logic             blink_phase_reg;
      logic             req_reg;
      logic             press;
      logic             green_start;
      logic             enter_walk;

      // Exactly one lamp lit: odd parity and not all three.
      assign lamp_ok[gi] = (red[gi] ^ yellow[gi] ^ green[gi]) & ~(red[gi] & yellow[gi] & green[gi]);

      // Press fires on the same edge the debounced level rises.
      assign press       = sync2_reg & ~db_level_reg & (db_cnt_reg == DB_LAST);
      assign green_start = green[gi] & ~green_prev_reg;
      assign enter_walk  = (state_reg == ST_IDLE) & green_start & req_reg & ~force_idle;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          db_level_reg <= 1'b0;
          db_cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != db_level_reg) begin
            if (db_cnt_reg == DB_LAST) begin
              db_level_reg <= sync2_reg;
              db_cnt_reg   <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            db_cnt_reg <= '0;
          end
        end
      end

      // Entry into WALK clears the latch even if a press lands on the same edge.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                req_reg <= 1'b0;
        else if (enter_walk)                      req_reg <= 1'b0;
        else if (press && state_reg != ST_WALK)   req_reg <= 1'b1;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          green_prev_reg  <= 1'b0;
          state_reg       <= ST_IDLE;
          timer_reg       <= '0;
          blink_cnt_reg   <= '0;
          blink_phase_reg <= 1'b1;
        end else begin
          green_prev_reg <= green[gi];
          if (force_idle || (state_reg != ST_IDLE && !green[gi])) begin
            state_reg       <= ST_IDLE;
            timer_reg       <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
          end else begin
            case (state_reg)
              ST_IDLE: begin
                if (enter_walk) begin
                  state_reg <= ST_WALK;
                  timer_reg <= '0;
                end
              end
              ST_WALK: begin
                if (timer_reg == WALK_LAST) begin
                  state_reg       <= ST_FLASH;
                  timer_reg       <= '0;
                  blink_cnt_reg   <= '0;
                  blink_phase_reg <= 1'b1;
                end else begin
                  timer_reg <= timer_reg + 1'b1;
                end
              end
              ST_FLASH: begin
                if (timer_reg == FLASH_LAST) begin
                  state_reg       <= ST_IDLE;
                  timer_reg       <= '0;
                  blink_cnt_reg   <= '0;
                  blink_phase_reg <= 1'b1;
                end else begin
                  timer_reg <= timer_reg + 1'b1;
                  if (blink_cnt_reg == BLINK_LAST) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                  end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                  end
                end
              end
              default: begin
                state_reg <= ST_IDLE;
                timer_reg <= '0;
              end
            endcase
          end
        end
      end

      assign walk_vec[gi]      = (state_reg == ST_WALK);
      assign dont_walk_vec[gi] = (state_reg == ST_IDLE) |
                                 ((state_reg == ST_FLASH) & blink_phase_reg);
      assign req_vec[gi]       = req_reg;

`ifdef PED_COUNTDOWN_EN
      logic [7:0] countdown_reg;
      logic       flash_enter;
      logic       flash_stay;

      assign flash_enter = (state_reg == ST_WALK) & green[gi] & (timer_reg == WALK_LAST);
      assign flash_stay  = (state_reg == ST_FLASH) & green[gi] & (timer_reg != FLASH_LAST);

      // Decrement at the close of each low half, i.e. the end of a full blink period.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          countdown_reg <= 8'd0;
        else if (force_idle || !(flash_enter || flash_stay))
          countdown_reg <= 8'd0;
        else if (flash_enter)
          countdown_reg <= 8'(FLASH_TIME / (2 * BLINK_HALF));
        else if (blink_cnt_reg == BLINK_LAST && !blink_phase_reg && countdown_reg != 8'd0)
          countdown_reg <= countdown_reg - 8'd1;
      end

      assign countdown_arr[gi] = countdown_reg;
`endif
    end
  endgenerate

  assign ped.walk_ns        = walk_vec[0];
  assign ped.walk_ew        = walk_vec[1];
  assign ped.dont_walk_ns   = dont_walk_vec[0];
  assign ped.dont_walk_ew   = dont_walk_vec[1];
  assign ped.req_pending_ns = req_vec[0];
  assign ped.req_pending_ew = req_vec[1];
  assign ped.fault          = fault_reg;
`ifdef PED_COUNTDOWN_EN
  assign ped.countdown_ns   = countdown_arr[0];
  assign ped.countdown_ew   = countdown_arr[1];
`endif

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed self-checking bench for ped_signal_controller with small timing parameters.
module tb_ped_signal_controller;
  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   errors = 0;

  ped_signal_controller_if pif ();

  ped_signal_controller #(
    .DEBOUNCE_CYCLES(4),
    .WALK_TIME(10),
    .FLASH_TIME(8),
    .BLINK_HALF(2),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ped(pif)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lamps(input logic [2:0] ns_ryg, input logic [2:0] ew_ryg);
    {pif.red_ns, pif.yellow_ns, pif.green_ns} = ns_ryg;
    {pif.red_ew, pif.yellow_ew, pif.green_ew} = ew_ryg;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pif.btn_ns = 1'b0;
    pif.btn_ew = 1'b0;
    set_lamps(3'b100, 3'b100);
    cyc(3);
    reset = 1'b0;
    cyc(1);
    tests++;
    if ({pif.walk_ns, pif.walk_ew, pif.dont_walk_ns, pif.dont_walk_ew,
         pif.req_pending_ns, pif.req_pending_ew, pif.fault} !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_state: got %b want 0011000",
               {pif.walk_ns, pif.walk_ew, pif.dont_walk_ns, pif.dont_walk_ew,
                pif.req_pending_ns, pif.req_pending_ew, pif.fault});
    end
  endtask

  task automatic test_debounce;
    pif.btn_ns = 1'b1;
    cyc(2);
    pif.btn_ns = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      tests++;
      if (pif.req_pending_ns !== 1'b0) begin
        errors++;
        $display("FAIL short_glitch c%0d: req_pending_ns=%b want 0", k, pif.req_pending_ns);
      end
    end
    pif.btn_ns = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      tests++;
      if (pif.req_pending_ns !== (k >= 6)) begin
        errors++;
        $display("FAIL debounce_rise c%0d: req_pending_ns=%b want %b", k, pif.req_pending_ns, k >= 6);
      end
    end
    pif.btn_ns = 1'b0;
    cyc(8);
  endtask

  task automatic test_walk_cycle;
    set_lamps(3'b001, 3'b100);
    for (int k = 1; k <= 19; k++) begin
      logic exp_walk, exp_dw;
      cyc(1);
      exp_walk = (k <= 10);
      exp_dw   = (k <= 10) ? 1'b0 : (k >= 19) ? 1'b1 : (((k - 11) / 2) % 2 == 0);
      tests++;
      if (pif.walk_ns !== exp_walk || pif.dont_walk_ns !== exp_dw) begin
        errors++;
        $display("FAIL walk_cycle c%0d: walk_ns=%b dont_walk_ns=%b want %b %b",
                 k, pif.walk_ns, pif.dont_walk_ns, exp_walk, exp_dw);
      end
      if (k == 1) begin
        tests++;
        if (pif.req_pending_ns !== 1'b0) begin
          errors++;
          $display("FAIL req_clear_on_entry: req_pending_ns=%b want 0", pif.req_pending_ns);
        end
      end
`ifdef PED_COUNTDOWN_EN
      begin
        logic [7:0] exp_cd;
        exp_cd = (k >= 11 && k <= 14) ? 8'd2 : (k >= 15 && k <= 18) ? 8'd1 : 8'd0;
        tests++;
        if (pif.countdown_ns !== exp_cd) begin
          errors++;
          $display("FAIL countdown c%0d: countdown_ns=%0d want %0d", k, pif.countdown_ns, exp_cd);
        end
      end
`endif
    end
    set_lamps(3'b010, 3'b100);
    cyc(2);
    set_lamps(3'b100, 3'b100);
    cyc(2);
  endtask

  task automatic test_mid_green_request;
    set_lamps(3'b100, 3'b001);
    cyc(2);
    pif.btn_ew = 1'b1;
    cyc(8);
    pif.btn_ew = 1'b0;
    tests++;
    if (pif.req_pending_ew !== 1'b1) begin
      errors++;
      $display("FAIL mid_green_latch: req_pending_ew=%b want 1", pif.req_pending_ew);
    end
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      tests++;
      if (pif.walk_ew !== 1'b0) begin
        errors++;
        $display("FAIL mid_green_no_walk c%0d: walk_ew=%b want 0", k, pif.walk_ew);
      end
    end
    set_lamps(3'b100, 3'b010);
    cyc(2);
    set_lamps(3'b100, 3'b100);
    cyc(3);
    set_lamps(3'b100, 3'b001);
    cyc(1);
    tests++;
    if (pif.walk_ew !== 1'b1 || pif.req_pending_ew !== 1'b0) begin
      errors++;
      $display("FAIL next_green_walk: walk_ew=%b req_pending_ew=%b want 1 0",
               pif.walk_ew, pif.req_pending_ew);
    end
    set_lamps(3'b100, 3'b010);
    cyc(2);
    set_lamps(3'b100, 3'b100);
    cyc(2);
  endtask

  task automatic test_abort;
    pif.btn_ns = 1'b1;
    cyc(8);
    pif.btn_ns = 1'b0;
    cyc(6);
    set_lamps(3'b001, 3'b100);
    cyc(5);
    tests++;
    if (pif.walk_ns !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_walk: walk_ns=%b want 1", pif.walk_ns);
    end
    set_lamps(3'b010, 3'b100);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      tests++;
      if (pif.walk_ns !== 1'b0 || pif.dont_walk_ns !== 1'b1 || pif.req_pending_ns !== 1'b0) begin
        errors++;
        $display("FAIL abort c%0d: walk_ns=%b dont_walk_ns=%b req_pending_ns=%b want 0 1 0",
                 k, pif.walk_ns, pif.dont_walk_ns, pif.req_pending_ns);
      end
    end
    set_lamps(3'b100, 3'b100);
    cyc(2);
  endtask

  task automatic test_fault;
    pif.btn_ns = 1'b1;
    pif.btn_ew = 1'b1;
    cyc(8);
    pif.btn_ns = 1'b0;
    pif.btn_ew = 1'b0;
    cyc(6);
    tests++;
    if (pif.req_pending_ns !== 1'b1 || pif.req_pending_ew !== 1'b1) begin
      errors++;
      $display("FAIL fault_setup: req_ns=%b req_ew=%b want 1 1", pif.req_pending_ns, pif.req_pending_ew);
    end
    set_lamps(3'b001, 3'b001);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      tests++;
      if ({pif.fault, pif.walk_ns, pif.walk_ew, pif.dont_walk_ns, pif.dont_walk_ew,
           pif.req_pending_ns, pif.req_pending_ew} !== 7'b1001111) begin
        errors++;
        $display("FAIL fault_active c%0d: got %b want 1001111", k,
                 {pif.fault, pif.walk_ns, pif.walk_ew, pif.dont_walk_ns, pif.dont_walk_ew,
                  pif.req_pending_ns, pif.req_pending_ew});
      end
    end
    set_lamps(3'b001, 3'b100);
    cyc(1);
    tests++;
    if (pif.fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: fault=%b want 0", pif.fault);
    end
    cyc(2);
    tests++;
    if (pif.walk_ns !== 1'b0 || pif.req_pending_ns !== 1'b1) begin
      errors++;
      $display("FAIL fault_no_auto_walk: walk_ns=%b req_pending_ns=%b want 0 1",
               pif.walk_ns, pif.req_pending_ns);
    end
    set_lamps(3'b000, 3'b100);
    cyc(1);
    tests++;
    if (pif.fault !== 1'b1) begin
      errors++;
      $display("FAIL dark_lamp_fault: fault=%b want 1", pif.fault);
    end
    set_lamps(3'b100, 3'b100);
    cyc(3);
  endtask

  task automatic test_reset_mid_flash;
    set_lamps(3'b001, 3'b100);
    cyc(13);
    tests++;
    if (pif.walk_ns !== 1'b0 || pif.dont_walk_ns !== 1'b0) begin
      errors++;
      $display("FAIL flash_before_reset: walk_ns=%b dont_walk_ns=%b want 0 0",
               pif.walk_ns, pif.dont_walk_ns);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({pif.walk_ns, pif.walk_ew, pif.dont_walk_ns, pif.dont_walk_ew,
         pif.req_pending_ns, pif.req_pending_ew, pif.fault} !== 7'b0011000) begin
      errors++;
      $display("FAIL async_reset: got %b want 0011000",
               {pif.walk_ns, pif.walk_ew, pif.dont_walk_ns, pif.dont_walk_ew,
                pif.req_pending_ns, pif.req_pending_ew, pif.fault});
    end
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_walk_cycle;
    test_mid_green_request;
    test_abort;
    test_fault;
    test_reset_mid_flash;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
